periph_bus_router: RTL
======================

Name: periph_bus_router

Overview:
- Parametrised successor to the SoC peripheral APB bus wrapper: one APB completer port, NB_SLV APB requester ports, and a run-time-programmable address map supplied as flattened start/end vectors.
- Adds behaviour the fixed-map wrapper lacks:
  - a registered request stage;
  - a PSLVERR response on unmapped addresses;
  - a per-transfer timeout watchdog that aborts hung peripherals.
- Sits between the SoC-bus-to-APB bridge and the peripheral APB slaves.

Parameters:
- NB_SLV, 13, number of downstream APB slaves (1..32)
- APB_ADDR_WIDTH, 32, address width
- APB_DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 256, max ACCESS-phase cycles before abort; 0 disables the watchdog
- ERR_RDATA, 32'hBADACCE5, read data returned on any error response, truncated or zero-extended to APB_DATA_WIDTH

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- start_addr_i  in  NB_SLV*APB_ADDR_WIDTH  region start per slave; slice i belongs to slave i
- end_addr_i  in  NB_SLV*APB_ADDR_WIDTH  region end per slave, inclusive
- paddr_i  in  APB_ADDR_WIDTH  upstream address
- pwdata_i  in  APB_DATA_WIDTH  upstream write data
- pwrite_i  in  1  upstream write flag
- psel_i  in  1  upstream select
- penable_i  in  1  upstream enable
- prdata_o  out  APB_DATA_WIDTH  upstream read data
- pready_o  out  1  upstream ready
- pslverr_o  out  1  upstream error
- paddr_o  out  APB_ADDR_WIDTH  downstream address, shared by all slaves
- pwdata_o  out  APB_DATA_WIDTH  downstream write data, shared
- pwrite_o  out  1  downstream write flag, shared
- psel_o  out  NB_SLV  one-hot downstream select
- penable_o  out  1  downstream enable, shared
- prdata_i  in  NB_SLV*APB_DATA_WIDTH  downstream read data
- pready_i  in  NB_SLV  downstream ready
- pslverr_i  in  NB_SLV  downstream error
- err_clr_i  in  1  clears the error log
- err_valid_o  out  1  sticky error-log valid flag
- err_addr_o  out  APB_ADDR_WIDTH  logged faulting address
- err_cause_o  out  2  logged cause: 01 decode miss, 10 timeout, 11 slave PSLVERR

Behaviour:
- Clocking and reset: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset value of every output is 0.
- Reset asserted mid-transfer: FSM returns to IDLE and psel_o/penable_o drop at the next edge. No completion is issued upstream; the upstream master restarts.
- Decode:
  - slave i hits when start_i <= paddr_i <= end_i;
  - a region with end < start never hits;
  - on overlapping regions the lowest index wins;
  - no hit is a miss.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: when psel_i=1 and penable_i=0, register paddr/pwdata/pwrite, the decoded index, and the hit/miss result.
    - Hit: go to SETUP.
    - Miss: go to RESP with error=1, rdata=ERR_RDATA.
  - SETUP: psel_o[idx]=1, penable_o=0, for exactly one cycle, then go to ACCESS.
  - ACCESS: psel_o[idx]=1, penable_o=1; the timeout counter increments every cycle.
    - pready_i[idx]=1: capture prdata_i[idx] and pslverr_i[idx], go to RESP.
    - Otherwise, after TIMEOUT_CYCLES cycles with TIMEOUT_CYCLES != 0: drop psel_o/penable_o, go to RESP with error=1, rdata=ERR_RDATA.
    - pready_i on the same cycle the timeout expires: pready_i wins.
  - RESP: pready_o=1 for exactly one cycle, with prdata_o (reads only, otherwise 0) and pslverr_o. Then go to IDLE.
- Latency to pready_o, counted from the upstream setup cycle T0:
  - hit with zero-wait slave: pready_o at T3;
  - miss: pready_o at T1;
  - slave inserting W wait states: pready_o at T3+W.
- Outside RESP: pready_o=0, prdata_o=0, pslverr_o=0.
- Downstream addr/data/write outputs hold their registered values from SETUP through the end of ACCESS.
- Upstream protocol: upstream must hold paddr_i/pwdata_i/pwrite_i stable until pready_o. psel_i is not re-sampled until the FSM is back in IDLE; a back-to-back request is accepted in the cycle after RESP.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1); the counter clears on entry to SETUP.

Optional Feature:
- Macro: PERIPH_BUS_ERR_LOG_EN.
- Defined:
  - on any error completion with err_valid_o=0, latch err_addr_o/err_cause_o and set err_valid_o at the RESP edge;
  - later errors are ignored until err_clr_i=1, which clears all three outputs next cycle;
  - a new error in the same cycle as err_clr_i is dropped (clear wins).
- Undefined: err_valid_o, err_addr_o and err_cause_o are tied to 0 and err_clr_i is ignored.
- Upstream behaviour is identical in both builds.

Test Plan:
- Map slave 3 = 0x1A10_4000..0x1A10_4FFF; read 0x1A10_4010, slave returns 0xCAFE0001 with zero wait -> psel_o=0x0008, pready_o at T3, prdata_o=0xCAFE0001, pslverr_o=0.
- Write 0x1A20_0000 (unmapped) -> no psel_o bit set, pready_o at T1, pslverr_o=1; with the macro defined, err_cause_o=01 and err_addr_o=0x1A20_0000.
- TIMEOUT_CYCLES=8, slave never asserts pready -> psel_o drops after 8 ACCESS cycles, pready_o=1, pslverr_o=1, prdata_o=0xBADACCE5, err_cause_o=10.
- Overlap: slaves 1 and 5 both cover 0x1A10_0000 -> only psel_o[1] asserted; slave 2 with end<start is never selected.
- Slave inserts 4 wait states then sets pslverr_i=1 -> pready_o at T7, pslverr_o=1; a second error then err_clr_i -> log holds the first error until the clear, then reads 0.
- Assert rst_i during ACCESS -> psel_o=0, penable_o=0, pready_o=0 at the next edge; the following transfer completes normally.

Source files
------------

// File: rtl/periph_bus_router.sv
// APB router: one upstream completer, NB_SLV downstream requesters, run-time address map,
// decode-miss PSLVERR and ACCESS-phase timeout watchdog. Optional error log: PERIPH_BUS_ERR_LOG_EN.
module periph_bus_router #(
    parameter int          NB_SLV         = 13,
    parameter int          APB_ADDR_WIDTH = 32,
    parameter int          APB_DATA_WIDTH = 32,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hBADACCE5
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NB_SLV*APB_ADDR_WIDTH-1:0]   start_addr_i,
    input  logic [NB_SLV*APB_ADDR_WIDTH-1:0]   end_addr_i,
    input  logic [APB_ADDR_WIDTH-1:0]          paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]          pwdata_i,
    input  logic                               pwrite_i,
    input  logic                               psel_i,
    input  logic                               penable_i,
    output logic [APB_DATA_WIDTH-1:0]          prdata_o,
    output logic                               pready_o,
    output logic                               pslverr_o,
    output logic [APB_ADDR_WIDTH-1:0]          paddr_o,
    output logic [APB_DATA_WIDTH-1:0]          pwdata_o,
    output logic                               pwrite_o,
    output logic [NB_SLV-1:0]                  psel_o,
    output logic                               penable_o,
    input  logic [NB_SLV*APB_DATA_WIDTH-1:0]   prdata_i,
    input  logic [NB_SLV-1:0]                  pready_i,
    input  logic [NB_SLV-1:0]                  pslverr_i,
    input  logic                               err_clr_i,
    output logic                               err_valid_o,
    output logic [APB_ADDR_WIDTH-1:0]          err_addr_o,
    output logic [1:0]                         err_cause_o
);

    localparam int IDX_W   = (NB_SLV > 1) ? $clog2(NB_SLV) : 1;
    localparam int TO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TO_W-1:0]           TO_LAST_C   = TO_W'(TO_LAST);
    localparam logic [APB_DATA_WIDTH-1:0] ERR_RDATA_W = APB_DATA_WIDTH'(ERR_RDATA);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_MISS    = 2'b01,
        CAUSE_TIMEOUT = 2'b10,
        CAUSE_SLVERR  = 2'b11
    } cause_t;

    state_t                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      write_q, write_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [TO_W-1:0]           cnt_q, cnt_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    cause_t                    cause_q, cause_d;

    logic                      dec_hit;
    logic [IDX_W-1:0]          dec_idx;
    logic [APB_DATA_WIDTH-1:0] sel_rdata;
    logic                      sel_ready;
    logic                      sel_err;

    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        // Scan downward so the lowest matching index is the last one assigned.
        for (int i = NB_SLV - 1; i >= 0; i--) begin
            if ((start_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] <= paddr_i) &&
                (paddr_i <= end_addr_i[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < NB_SLV; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_rdata = prdata_i[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                sel_ready = pready_i[i];
                sel_err   = pslverr_i[i];
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    addr_d  = paddr_i;
                    wdata_d = pwdata_i;
                    write_d = pwrite_i;
                    idx_d   = dec_idx;
                    if (dec_hit) begin
                        state_d = SETUP;
                        cnt_d   = '0;
                    end else begin
                        state_d = RESP;
                        cause_d = CAUSE_MISS;
                        rdata_d = pwrite_i ? '0 : ERR_RDATA_W;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A ready slave wins over a watchdog expiring in the same cycle.
                if (sel_ready) begin
                    state_d = RESP;
                    cause_d = sel_err ? CAUSE_SLVERR : CAUSE_NONE;
                    rdata_d = write_q ? '0 : (sel_err ? ERR_RDATA_W : sel_rdata);
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST_C)) begin
                    state_d = RESP;
                    cause_d = CAUSE_TIMEOUT;
                    rdata_d = write_q ? '0 : ERR_RDATA_W;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        psel_o = '0;
        for (int i = 0; i < NB_SLV; i++) begin
            psel_o[i] = ((state_q == SETUP) || (state_q == ACCESS)) && (idx_q == IDX_W'(i));
        end
    end

    assign penable_o = (state_q == ACCESS);
    assign paddr_o   = addr_q;
    assign pwdata_o  = wdata_q;
    assign pwrite_o  = write_q;
    assign pready_o  = (state_q == RESP);
    assign prdata_o  = (state_q == RESP) ? rdata_q : '0;
    assign pslverr_o = (state_q == RESP) && (cause_q != CAUSE_NONE);

`ifdef PERIPH_BUS_ERR_LOG_EN
    logic                      err_valid_q;
    logic [APB_ADDR_WIDTH-1:0] err_addr_q;
    logic [1:0]                err_cause_q;

    // The first error is captured at the edge closing its RESP cycle; a clear in that cycle wins.
    always_ff @(posedge clk_i) begin
        if (rst_i || err_clr_i) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_cause_q <= 2'b00;
        end else if ((state_q == RESP) && (cause_q != CAUSE_NONE) && !err_valid_q) begin
            err_valid_q <= 1'b1;
            err_addr_q  <= addr_q;
            err_cause_q <= cause_q;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
    assign err_cause_o = err_cause_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign err_valid_o    = 1'b0;
    assign err_addr_o     = '0;
    assign err_cause_o    = 2'b00;
`endif

endmodule
